decoder_scan_seq: RTL and testbench

- Parametrised, registered successor to the team's fixed 4-to-16 combinational decoder.
- Decodes a SEL_W-bit index into a one-hot OUT_W-bit vector.
- Two modes:
  - DIRECT: hold a selected line.
  - SCAN: walk the active line through all outputs with a programmable dwell time per position.
- Sits between the control FSM and chip-select or row-enable fabric. Index loads use a valid/ready handshake.

---
 rtl/decoder_scan_seq.sv | 183 ++++++++++++++++++
 tb/tb_decoder_scan_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered SEL_W-to-OUT_W one-hot decoder with a DIRECT
// hold mode and a SCAN mode that walks the active line with a programmable
// dwell per position. Loads use a sel_valid/sel_ready handshake.
//
// Build option: DECODER_ACTIVE_LOW_EN inverts out (active line driven low,
// idle/reset value all ones) for direct use on active-low chip selects.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no line driven, waiting for a load
// ST_DIRECT | holding the loaded line; further loads accepted
// ST_SCAN   | walking the active line; loads blocked until en drops

module decoder_scan_seq #(
    parameter int SEL_W   = 4,
    parameter int OUT_W   = 16,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               wrap,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // One extra bit so the range check also works when OUT_W == 2**SEL_W.
    localparam logic [SEL_W:0]   OUT_W_EXT = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUT_W - 1);

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0]   dwell_rld_q, dwell_rld_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;

    logic                 hs;
    logic                 sel_ok;
    logic                 at_last;
    logic                 dwell_zero;
    logic [SEL_W-1:0]     next_idx;

    // Decode by explicit compare so an index >= OUT_W can never set a bit.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if ({1'b0, idx} == (SEL_W + 1)'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign sel_ready  = en && (state_q != ST_SCAN);
    assign hs         = sel_valid && sel_ready;
    assign sel_ok     = ({1'b0, sel_in} < OUT_W_EXT);
    assign at_last    = (cur_sel_q == LAST_IDX);
    assign next_idx   = at_last ? '0 : (cur_sel_q + SEL_W'(1));
    assign dwell_zero = (dwell_cnt_q == '0);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: en low always returns to IDLE; rejected loads do not move.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DIRECT: begin
                    if (hs && sel_ok) begin
                        state_d = mode ? ST_SCAN : ST_DIRECT;
                    end
                end
                ST_SCAN: begin
                    state_d = ST_SCAN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output/datapath next values: load, scan advance with dwell countdown.
    always_comb begin
        out_d       = out_q;
        cur_sel_d   = cur_sel_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_rld_d = dwell_rld_q;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        if (!en) begin
            out_d       = '0;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DIRECT: begin
                    if (hs) begin
                        if (sel_ok) begin
                            cur_sel_d = sel_in;
                            out_d     = decode(sel_in);
                            if (mode) begin
                                dwell_cnt_d = dwell;
                                dwell_rld_d = dwell;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (dwell_zero) begin
                        cur_sel_d   = next_idx;
                        out_d       = decode(next_idx);
                        dwell_cnt_d = dwell_rld_q;
                        wrap_d      = at_last;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    out_d       = '0;
                    dwell_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            cur_sel_q   <= '0;
            dwell_cnt_q <= '0;
            dwell_rld_q <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            cur_sel_q   <= cur_sel_d;
            dwell_cnt_q <= dwell_cnt_d;
            dwell_rld_q <= dwell_rld_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    assign cur_sel = cur_sel_q;
    assign busy    = (state_q != ST_IDLE);
    assign wrap    = wrap_q;
    assign err     = err_q;

`ifdef DECODER_ACTIVE_LOW_EN
    assign out = ~out_q;
`else
    assign out = out_q;
`endif

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: a 16-output and a 12-output instance share
// stimulus. Directed table, hand sequences, then random traffic compared
// against a model that derives the scan position arithmetically.
module tb_decoder_scan_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, mode, sel_valid;
    logic [3:0] sel_in;
    logic [7:0] dwell;

    logic [15:0] out16;
    logic [3:0]  cur16;
    logic        ready16, busy16, wrap16, err16;
    logic [11:0] out12;
    logic [3:0]  cur12;
    logic        ready12, busy12, wrap12, err12;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_scan_seq u_dut16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .sel_valid(sel_valid), .sel_ready(ready16), .dwell(dwell),
        .out(out16), .cur_sel(cur16), .busy(busy16), .wrap(wrap16), .err(err16)
    );

    decoder_scan_seq #(.SEL_W(4), .OUT_W(12), .DWELL_W(8)) u_dut12 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .sel_valid(sel_valid), .sel_ready(ready12), .dwell(dwell),
        .out(out12), .cur_sel(cur12), .busy(busy12), .wrap(wrap12), .err(err12)
    );

    function automatic logic [15:0] pol16(input logic [15:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [11:0] pol12(input logic [11:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic m,
                         input logic [3:0] s, input logic [7:0] d);
        rst = r; en = e; sel_valid = v; mode = m; sel_in = s; dwell = d;
    endtask

    // Reference model: index during a scan = (start + elapsed/(dwell+1)) mod W.
    int m_on[2], m_scan[2], m_idx[2], m_start[2], m_t[2], m_dw[2], m_wrap[2], m_err[2];

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_on[k] = 0; m_scan[k] = 0; m_idx[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
            end else if (!en) begin
                m_on[k] = 0; m_scan[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
            end else begin
                m_wrap[k] = 0;
                m_err[k]  = 0;
                if (m_scan[k] != 0) begin
                    m_t[k]++;
                    m_idx[k]  = (m_start[k] + m_t[k] / (m_dw[k] + 1)) % width_of(k);
                    m_wrap[k] = ((m_t[k] % (m_dw[k] + 1)) == 0 && m_idx[k] == 0) ? 1 : 0;
                end else if (sel_valid) begin
                    if (int'(sel_in) >= width_of(k)) begin
                        m_err[k] = 1;
                    end else begin
                        m_idx[k] = int'(sel_in);
                        m_on[k]  = 1;
                        if (mode) begin
                            m_scan[k]  = 1;
                            m_start[k] = int'(sel_in);
                            m_t[k]     = 0;
                            m_dw[k]    = int'(dwell);
                        end
                    end
                end
            end
        end
    end

    task automatic check_models();
        logic [31:0] oh0, oh1;
        oh0 = (m_on[0] != 0) ? (32'd1 << m_idx[0]) : 32'd0;
        oh1 = (m_on[1] != 0) ? (32'd1 << m_idx[1]) : 32'd0;
        chk("rnd16_out",   32'(out16),   32'(pol16(oh0[15:0])));
        chk("rnd16_cur",   32'(cur16),   32'(m_idx[0]));
        chk("rnd16_busy",  32'(busy16),  32'(m_on[0]));
        chk("rnd16_ready", 32'(ready16), 32'(en && m_scan[0] == 0));
        chk("rnd16_wrap",  32'(wrap16),  32'(m_wrap[0]));
        chk("rnd16_err",   32'(err16),   32'(m_err[0]));
        chk("rnd12_out",   32'(out12),   32'(pol12(oh1[11:0])));
        chk("rnd12_cur",   32'(cur12),   32'(m_idx[1]));
        chk("rnd12_busy",  32'(busy12),  32'(m_on[1]));
        chk("rnd12_ready", 32'(ready12), 32'(en && m_scan[1] == 0));
        chk("rnd12_wrap",  32'(wrap12),  32'(m_wrap[1]));
        chk("rnd12_err",   32'(err12),   32'(m_err[1]));
    endtask

    typedef struct {
        logic        r, e, v, m;
        logic [3:0]  s;
        logic [7:0]  d;
        logic [15:0] o;
        logic [3:0]  c;
        logic        b, rd, w, er;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_a[10];
        int wraps;
        // inputs r e v m s d | expected out cur busy ready wrap err (16-wide)
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 16'h0000,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0,  0, 0, 16'h0000,  0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0,  5, 0, 16'h0020,  5, 1, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,  0, 0, 16'h0020,  5, 1, 1, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 15, 0, 16'h8000, 15, 1, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 1,  3, 1, 16'h0008,  3, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 0,  9, 0, 16'h0008,  3, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0,  0, 0, 16'h0010,  4, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0,  0, 0, 16'h0010,  4, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 0,  2, 0, 16'h0000,  4, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 0,  0, 0, 16'h0000,  4, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 1, 1,  0, 0, 16'h0001,  0, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0,  0, 0, 16'h0002,  1, 1, 0, 0, 0};
        tbl[13] = '{0, 1, 1, 0,  6, 0, 16'h0004,  2, 1, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].m, tbl[i].s, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_out", i),   32'(out16),   32'(pol16(tbl[i].o)));
            chk($sformatf("tbl%0d_cur", i),   32'(cur16),   32'(tbl[i].c));
            chk($sformatf("tbl%0d_busy", i),  32'(busy16),  32'(tbl[i].b));
            chk($sformatf("tbl%0d_ready", i), 32'(ready16), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_wrap", i),  32'(wrap16),  32'(tbl[i].w));
            chk($sformatf("tbl%0d_err", i),   32'(err16),   32'(tbl[i].er));
        end

        // Scan from 14 with dwell 2: three cycles per index, wrap on bit 0.
        seq_a = '{14, 14, 14, 15, 15, 15, 0, 0, 0, 1};
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 1, 1, 14, 2);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk($sformatf("scanA%0d_out", j),   32'(out16),   32'(pol16(16'd1 << seq_a[j])));
            chk($sformatf("scanA%0d_wrap", j),  32'(wrap16),  32'(j == 6));
            chk($sformatf("scanA%0d_ready", j), 32'(ready16), 32'd0);
            drive(0, 1, 1, 0, 3, 0);
        end

        // Fast scan from 0 with dwell 0: one index per cycle, wrap every 16.
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("fast_first_out",  32'(out16),  32'(pol16(16'h0001)));
        chk("fast_first_wrap", 32'(wrap16), 32'd0);
        drive(0, 1, 0, 0, 0, 0);
        wraps = 0;
        for (int j = 1; j < 34; j++) begin
            @(negedge clk);
            chk($sformatf("fast%0d_out", j),  32'(out16),  32'(pol16(16'd1 << (j % 16))));
            chk($sformatf("fast%0d_wrap", j), 32'(wrap16), 32'((j % 16) == 0));
            if (wrap16) wraps++;
        end
        chk("fast_wrap_count", 32'(wraps), 32'd2);

        // Reset mid-scan at index 7.
        for (int n = 0; n < 20 && cur16 != 4'd7; n++) @(negedge clk);
        chk("wait_idx7", 32'(cur16), 32'd7);
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_mid_out",  32'(out16),  32'(pol16(16'h0000)));
        chk("rst_mid_cur",  32'(cur16),  32'd0);
        chk("rst_mid_busy", 32'(busy16), 32'd0);

        // Range check on the 12-output instance.
        drive(0, 1, 1, 0, 13, 0);
        @(negedge clk);
        chk("r12_rej_err",  32'(err12),  32'd1);
        chk("r12_rej_out",  32'(out12),  32'(pol12(12'h000)));
        chk("r12_rej_busy", 32'(busy12), 32'd0);
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r12_err_clr", 32'(err12), 32'd0);
        drive(0, 1, 1, 0, 11, 0);
        @(negedge clk);
        chk("r12_ok_out", 32'(out12), 32'(pol12(12'h800)));
        chk("r12_ok_cur", 32'(cur12), 32'd11);
        drive(0, 1, 1, 1, 13, 3);
        @(negedge clk);
        chk("r12_rej2_err",   32'(err12),   32'd1);
        chk("r12_rej2_out",   32'(out12),   32'(pol12(12'h800)));
        chk("r12_rej2_cur",   32'(cur12),   32'd11);
        chk("r12_rej2_busy",  32'(busy12),  32'd1);
        chk("r12_rej2_ready", 32'(ready12), 32'd1);
        drive(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r12_err_clr2", 32'(err12), 32'd0);

        // Random traffic against the reference model.
        drive(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 24) != 0,
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
            @(negedge clk);
            check_models();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
